// File: rtl/rtc_burst_ctrl_pkg.sv
// Shared definitions for the RTC multiplexed-bus burst controller: state codes,
// default timing and the idle levels of the bus outputs.
package rtc_burst_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_GAP_A = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_GAP_D = 3'd4;
    localparam logic [2:0] ST_NEXT  = 3'd5;
    localparam logic [2:0] ST_FIN   = 3'd6;

    localparam int DEF_T_ADDR    = 4;
    localparam int DEF_T_STROBE  = 8;
    localparam int DEF_T_GAP     = 4;
    localparam int DEF_LAST_ADDR = 8;

    typedef struct packed {
        logic       cs_n;
        logic       ale;
        logic       rd_n;
        logic       wr_n;
        logic       oe;
        logic [7:0] ad;
    } bus_t;

    localparam bus_t BUS_IDLE = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

    // Phase counter preload: a phase of t clocks counts t-1 down to 0.
    function automatic logic [3:0] phase_load(input int t);
        return 4'(t - 1);
    endfunction

endpackage

// File: rtl/rtc_addr_cnt.sv
// Register-address counter for a burst: clears at burst start, steps once per
// transaction and saturates at LAST, flagging the terminal address.
module rtc_addr_cnt #(
    parameter int LAST = 8
) (
    input  logic       clkCTRL,
    input  logic       resetCTRL,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] cnt,
    output logic [3:0] cnt_next,
    output logic       tc
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (en && (cnt_q != 4'(LAST))) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clkCTRL) begin
        if (resetCTRL) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;
    assign tc       = (cnt_q == 4'(LAST));

endmodule

// File: rtl/rtc_burst_ctrl.sv
// Burst sequencer for a multiplexed-address RTC bus: walks register addresses
// 0..LAST_ADDR, issuing an ALE address phase and an RD/WR strobe phase for each.
module rtc_burst_ctrl
    import rtc_burst_ctrl_pkg::*;
#(
    parameter int T_ADDR    = DEF_T_ADDR,
    parameter int T_STROBE  = DEF_T_STROBE,
    parameter int T_GAP     = DEF_T_GAP,
    parameter int LAST_ADDR = DEF_LAST_ADDR
) (
    input  logic       clkCTRL,
    input  logic       resetCTRL,
    input  logic       start,
    input  logic       wr_mode,
    input  logic [7:0] wr_data,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ale,
    output logic       rd_n,
    output logic       wr_n,
    output logic [3:0] addr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done
);

    logic [2:0] state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic       wr_mode_q, wr_mode_d;
    bus_t       bus_q, bus_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       phase_done;
    logic       cnt_clr, cnt_en;
    logic [3:0] addr_cnt, addr_cnt_next;
    logic       addr_tc;

    rtc_addr_cnt #(.LAST(LAST_ADDR)) u_addr_cnt (
        .clkCTRL  (clkCTRL),
        .resetCTRL(resetCTRL),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .cnt      (addr_cnt),
        .cnt_next (addr_cnt_next),
        .tc       (addr_tc)
    );

    assign phase_done = (phase_q == 4'd0);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        wr_mode_d = wr_mode_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ADDR;
                    phase_d   = phase_load(T_ADDR);
                    wr_mode_d = wr_mode;
                    cnt_clr   = 1'b1;
                end
            end
            ST_ADDR: begin
                if (phase_done) begin
                    state_d = ST_GAP_A;
                    phase_d = phase_load(T_GAP);
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            ST_GAP_A: begin
                if (phase_done) begin
                    state_d = ST_DATA;
                    phase_d = phase_load(T_STROBE);
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            ST_DATA: begin
                if (phase_done) begin
                    state_d = ST_GAP_D;
                    phase_d = phase_load(T_GAP);
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            ST_GAP_D: begin
                if (phase_done) begin
                    state_d = ST_NEXT;
                    phase_d = 4'd0;
                end else begin
                    phase_d = phase_q - 4'd1;
                end
            end
            ST_NEXT: begin
                if (addr_tc) begin
                    state_d = ST_FIN;
                    phase_d = 4'd0;
                end else begin
                    state_d = ST_ADDR;
                    phase_d = phase_load(T_ADDR);
                    cnt_en  = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                phase_d = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered bus lines up
    // with the state register on the same clock.
    always_comb begin
        bus_d      = BUS_IDLE;
        rd_valid_d = (state_q == ST_DATA) && phase_done && !wr_mode_q;
        rd_data_d  = rd_valid_d ? ad_in : rd_data_q;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_FIN);
        case (state_d)
            ST_ADDR: begin
                bus_d.cs_n = 1'b0;
                bus_d.ale  = 1'b1;
                bus_d.oe   = 1'b1;
                bus_d.ad   = {4'b0000, addr_cnt_next};
            end
            ST_GAP_A, ST_GAP_D, ST_NEXT: begin
                bus_d.cs_n = 1'b0;
            end
            ST_DATA: begin
                bus_d.cs_n = 1'b0;
                if (wr_mode_q) begin
                    bus_d.wr_n = 1'b0;
                    bus_d.oe   = 1'b1;
                    bus_d.ad   = (state_q == ST_DATA) ? bus_q.ad : wr_data;
                end else begin
                    bus_d.rd_n = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clkCTRL) begin
        if (resetCTRL) begin
            state_q    <= ST_IDLE;
            phase_q    <= 4'd0;
            wr_mode_q  <= 1'b0;
            bus_q      <= BUS_IDLE;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            wr_mode_q  <= wr_mode_d;
            bus_q      <= bus_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ad_out   = bus_q.ad;
    assign ad_oe    = bus_q.oe;
    assign cs_n     = bus_q.cs_n;
    assign ale      = bus_q.ale;
    assign rd_n     = bus_q.rd_n;
    assign wr_n     = bus_q.wr_n;
    assign addr     = addr_cnt;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/rtc_burst_ctrl.md
RTC_BURST_CTRL -- requirements
Module: rtc_burst_ctrl

Interface
REQ-001 SHALL have parameter T_ADDR, default 4, giving address-phase length in clocks (legal range 1..15).
REQ-002 SHALL have parameter T_STROBE, default 8, giving RD/WR strobe-low length in clocks (legal range 1..15).
REQ-003 SHALL have parameter T_GAP, default 4, giving the idle clocks after each phase (legal range 1..15).
REQ-004 SHALL have parameter LAST_ADDR, default 8, giving the final register address of a burst (legal range 0..15).
REQ-005 SHALL have port clkCTRL, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port resetCTRL, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: burst request, sampled in IDLE only.
REQ-008 SHALL have port wr_mode, input, 1 bit: 1 = write burst, 0 = read burst; sampled with start.
REQ-009 SHALL have port wr_data, input, 8 bits: write byte for the current address, sampled at DATA entry.
REQ-010 SHALL have port ad_in, input, 8 bits: bus read data.
REQ-011 SHALL have port ad_out, output, 8 bits: bus drive value.
REQ-012 SHALL have port ad_oe, output, 1 bit: bus drive enable.
REQ-013 SHALL have ports cs_n, ale, rd_n and wr_n, outputs, 1 bit each: bus control, active levels as named.
REQ-014 SHALL have port addr, output, 4 bits: the current register address.
REQ-015 SHALL have port rd_data, output, 8 bits, and port rd_valid, output, 1 bit: captured read byte and its one-clock qualifier.
REQ-016 SHALL have ports busy and done, outputs, 1 bit each: busy is high during a burst; done is a one-clock end-of-burst pulse.

Function
REQ-017 SHALL implement the states IDLE, ADDR, GAP_A, DATA, GAP_D, NEXT and FIN.
REQ-018 SHALL go IDLE -> ADDR on start=1 and capture wr_mode at that edge; the address counter is 0 on entry.
REQ-019 ADDR SHALL last T_ADDR clocks with cs_n=0, ale=1, ad_oe=1, ad_out={4'b0,addr}.
REQ-020 GAP_A SHALL last T_GAP clocks with cs_n=0, ale=0, ad_oe=0.
REQ-021 DATA SHALL last T_STROBE clocks with rd_n=0 if reading or wr_n=0 if writing; when writing, ad_oe=1 and ad_out holds wr_data as captured at DATA entry.
REQ-022 On a read, the last DATA clock SHALL register ad_in into rd_data, and rd_valid SHALL pulse for one clock on the following cycle with addr still valid.
REQ-023 GAP_D SHALL last T_GAP clocks with all strobes inactive and cs_n=0.
REQ-024 NEXT (1 clock) SHALL go to FIN if addr==LAST_ADDR; otherwise it SHALL increment addr and go to ADDR.
REQ-025 FIN (1 clock) SHALL drive cs_n=1, pulse done, and return to IDLE.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 start while busy SHALL be ignored, with no queuing.
REQ-028 rd_n and wr_n SHALL never be low simultaneously, and ale SHALL never be high while rd_n or wr_n is low.
REQ-029 The phase counter SHALL be 4 bits, load (T-1) on phase entry, and advance on reaching 0.
REQ-030 addr SHALL never exceed LAST_ADDR, with no wrap-around within a burst.
REQ-031 With LAST_ADDR=0, a burst SHALL be a single transaction.
REQ-032 start asserted in the FIN cycle SHALL be ignored; the next burst may begin no earlier than the clock after IDLE is re-entered.

Reset
REQ-033 resetCTRL=1 at a clock edge SHALL force IDLE, addr=0 and the phase counter to 0.
REQ-034 resetCTRL=1 SHALL force cs_n=1, ale=0, rd_n=1, wr_n=1, ad_oe=0, ad_out=0, rd_data=0, rd_valid=0, busy=0 and done=0.
REQ-035 Reset SHALL take priority over all other inputs, including mid-burst, with no done pulse generated.

Structure
REQ-036 A shared package SHALL hold the state encoding (3 bits), the default timing constants and the bus idle levels.
REQ-037 The address sequencing SHALL be one sub-module, rtc_addr_cnt: a 4-bit counter with clear, enable and terminal-count flag, clocked by clkCTRL and reset by resetCTRL.
REQ-038 All outputs SHALL be registered.

Verification
REQ-039 Read burst with defaults, start=1 for 1 clock -> 9 transactions at addr 0..8, each 4+4+8+4+1 clocks; done pulses once; rd_valid pulses 9 times.
REQ-040 Write burst with wr_data=8'hA5 -> wr_n low 8 clocks per address with ad_out=8'hA5 and ad_oe=1; rd_valid never asserts.
REQ-041 Reset asserted during DATA at addr=3 -> next clock shows all strobes inactive, cs_n=1, busy=0 and no done pulse; a new start begins at addr 0.
REQ-042 start held high continuously through a burst -> no restart until IDLE; the second burst starts exactly one clock after done.
REQ-043 LAST_ADDR=0, T_STROBE=1 -> single transaction; rd_data equals ad_in sampled at the strobe clock.
REQ-044 Assertion monitors on every clock -> rd_n and wr_n never both low; ale never high with a strobe low.
